// File: rtl/usb_pkg.sv
// Shared types for the USB receive packet parser: PID codes, error codes, parser states.
package usb_pkg;

   typedef enum logic [3:0] {
      OUT   = 4'b0001,
      IN    = 4'b1001,
      SOF   = 4'b0101,
      SETUP = 4'b1101,
      DATA0 = 4'b0011,
      DATA1 = 4'b1011,
      ACK   = 4'b0010,
      NAK   = 4'b1010,
      STALL = 4'b1110
   } pid_t;

   typedef enum logic [2:0] {
      ERR_OK      = 3'd0,
      ERR_PID     = 3'd1,
      ERR_LEN     = 3'd2,
      ERR_RERR    = 3'd3,
      ERR_OVF     = 3'd4,
      ERR_UNKNOWN = 3'd5
   } pkt_err_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PID,
      ST_TOKEN,
      ST_DATA,
      ST_HSHK,
      ST_DRAIN,
      ST_DONE
   } parser_state_t;

   function automatic logic pid_known(input logic [3:0] p);
      case (p)
         OUT, IN, SOF, SETUP, DATA0, DATA1, ACK, NAK, STALL: return 1'b1;
         default:                                            return 1'b0;
      endcase
   endfunction

   // Tokens and SOF share the two-byte body layout.
   function automatic parser_state_t pid_state(input logic [3:0] p);
      case (p)
         OUT, IN, SOF, SETUP: return ST_TOKEN;
         DATA0, DATA1:        return ST_DATA;
         default:             return ST_HSHK;
      endcase
   endfunction

   function automatic logic [6:0] sat7(input logic [15:0] v);
      return (v > 16'd127) ? 7'd127 : v[6:0];
   endfunction

endpackage

// File: rtl/usb_rx_fifo.sv
// Synchronous payload FIFO; push while full is accepted only when a pop happens in the same cycle.
module usb_rx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic             do_push, do_pop;

   assign full     = (count == FULL_CNT);
   assign empty    = (count == '0);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/usb_pkt_parser.sv
// Packet parser behind the USB receive front end: PID decode, token fields, CRC16 strip, payload FIFO.
// Define USB_PKT_PID_CHECK_EN to enable the PID complement check (error code 1).
module usb_pkt_parser
   import usb_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int MAX_PAYLOAD = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rcv_data,
   input  logic        byte_valid,
   input  logic        rcving,
   input  logic        r_error,
   output logic [3:0]  pid,
   output logic        pid_valid,
   output logic [6:0]  tok_addr,
   output logic [3:0]  tok_endp,
   output logic [10:0] sof_frame,
   output logic        tok_valid,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        pkt_done,
   output logic [2:0]  pkt_err,
   output logic [6:0]  byte_count
);

   localparam logic [15:0] MAX_PUSH = 16'(MAX_PAYLOAD);

   parser_state_t state, st_b;
   pkt_err_t      err_q, byte_err, first_err, end_err;
   logic          rcving_q, r_seen, rcv_rise, pid_chk_fail, push_en, len_bad, tok_ok;
   logic          fifo_pop, fifo_full, fifo_empty;
   logic [1:0]    tok_cnt, tok_cnt_b, hold_cnt, hold_cnt_b;
   logic [7:0]    d0, d1;
   logic [15:0]   push_cnt;
   logic [3:0]    pid_in;

   assign pid_in    = rcv_data[3:0];
   assign rcv_rise  = rcving && !rcving_q;
   assign out_valid = !fifo_empty;
   assign fifo_pop  = out_valid && out_ready;

`ifdef USB_PKT_PID_CHECK_EN
   assign pid_chk_fail = (rcv_data[7:4] != ~rcv_data[3:0]);
`else
   assign pid_chk_fail = 1'b0;
`endif

   // Effect of this cycle's byte; the end-of-packet verdict is taken after it so a byte
   // arriving together with the falling rcving still counts.
   always_comb begin
      st_b       = state;
      tok_cnt_b  = tok_cnt;
      hold_cnt_b = hold_cnt;
      byte_err   = ERR_OK;
      push_en    = 1'b0;
      if (byte_valid) begin
         unique case (state)
            ST_PID: begin
               if (pid_chk_fail)    byte_err = ERR_PID;
               else if (!pid_known(pid_in)) byte_err = ERR_UNKNOWN;
               else                 st_b = pid_state(pid_in);
            end
            ST_TOKEN: begin
               if (tok_cnt == 2'd2) byte_err = ERR_LEN;
               else                 tok_cnt_b = tok_cnt + 2'd1;
            end
            ST_DATA: begin
               if (hold_cnt == 2'd2) begin
                  if (push_cnt == MAX_PUSH)        byte_err = ERR_LEN;
                  else if (fifo_full && !fifo_pop) byte_err = ERR_OVF;
                  else                             push_en = !r_error;
               end else begin
                  hold_cnt_b = hold_cnt + 2'd1;
               end
            end
            ST_HSHK: byte_err = ERR_LEN;
            default: ;
         endcase
      end
      if (byte_err != ERR_OK || r_error) st_b = ST_DRAIN;

      first_err = (err_q != ERR_OK) ? err_q : byte_err;
      len_bad   = (st_b == ST_PID) ||
                  (st_b == ST_TOKEN && tok_cnt_b != 2'd2) ||
                  (st_b == ST_DATA && hold_cnt_b != 2'd2);
      if (r_seen || r_error)        end_err = ERR_RERR;
      else if (first_err != ERR_OK) end_err = first_err;
      else if (len_bad)             end_err = ERR_LEN;
      else                          end_err = ERR_OK;
      tok_ok = (end_err == ERR_OK) && (st_b == ST_TOKEN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         rcving_q   <= rcving;
         err_q      <= ERR_OK;
         r_seen     <= 1'b0;
         tok_cnt    <= '0;
         hold_cnt   <= '0;
         push_cnt   <= '0;
         d0         <= '0;
         d1         <= '0;
         pid        <= '0;
         pid_valid  <= 1'b0;
         tok_addr   <= '0;
         tok_endp   <= '0;
         sof_frame  <= '0;
         tok_valid  <= 1'b0;
         pkt_done   <= 1'b0;
         pkt_err    <= '0;
         byte_count <= '0;
      end else begin
         rcving_q   <= rcving;
         pid_valid  <= 1'b0;
         tok_valid  <= 1'b0;
         pkt_done   <= 1'b0;
         pkt_err    <= '0;
         byte_count <= '0;
         unique case (state)
            ST_IDLE, ST_DONE: begin
               state    <= rcv_rise ? ST_PID : ST_IDLE;
               err_q    <= ERR_OK;
               r_seen   <= r_error && rcv_rise;
               tok_cnt  <= '0;
               hold_cnt <= '0;
               push_cnt <= '0;
            end
            default: begin
               if (byte_valid) begin
                  if (state == ST_PID) begin
                     pid       <= pid_in;
                     pid_valid <= 1'b1;
                  end
                  if (state == ST_TOKEN && tok_cnt == 2'd0) begin
                     tok_addr       <= rcv_data[6:0];
                     tok_endp[0]    <= rcv_data[7];
                     sof_frame[7:0] <= rcv_data;
                  end
                  if (state == ST_TOKEN && tok_cnt == 2'd1) begin
                     tok_endp[3:1]   <= rcv_data[2:0];
                     sof_frame[10:8] <= rcv_data[2:0];
                  end
                  if (state == ST_DATA) begin
                     d0 <= d1;
                     d1 <= rcv_data;
                  end
               end
               tok_cnt  <= tok_cnt_b;
               hold_cnt <= hold_cnt_b;
               if (push_en)           push_cnt <= push_cnt + 16'd1;
               if (err_q == ERR_OK)   err_q    <= byte_err;
               if (r_error)           r_seen   <= 1'b1;
               if (!rcving) begin
                  state      <= ST_DONE;
                  pkt_done   <= 1'b1;
                  pkt_err    <= end_err;
                  byte_count <= sat7(push_cnt + {15'd0, push_en});
                  tok_valid  <= tok_ok;
               end else begin
                  state <= st_b;
               end
            end
         endcase
      end
   end

   usb_rx_fifo #(
      .WIDTH(8),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push_en),
      .push_data(d0),
      .pop      (fifo_pop),
      .pop_data (out_data),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

endmodule
